// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC datapath stages (lookup, key, cipher add):
// FSM state encoding, default field/curve constants and the point-at-infinity
// flag convention.
package ecc_pkg;

  // Default field and curve: GF(23), y^2 = x^3 + x + B.
  localparam int DEF_W = 8;
  localparam int DEF_P = 23;
  localparam int DEF_A = 1;

  // A point travels as (x, y, inf); when inf is set, x and y carry no meaning.
  localparam logic PT_INF    = 1'b1;
  localparam logic PT_FINITE = 1'b0;

  // Point-addition sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_INV,
    ST_SLOPE,
    ST_XR,
    ST_YR
  } add_state_t;

endpackage

// File: rtl/ecc_cipher_add_if.sv
// Operand/result bundle of the cipher-point adder. The master presents the two
// points with a strobe. The slave reports busy and returns the sum with a
// one-cycle strobe.
interface ecc_cipher_add_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic [W-1:0] mx;
  logic [W-1:0] my;
  logic         m_inf;
  logic [W-1:0] kx;
  logic [W-1:0] ky;
  logic         k_inf;
  logic         busy;
  logic         out_valid;
  logic [W-1:0] cx;
  logic [W-1:0] cy;
  logic         c_inf;

  modport master (
    output in_valid, mx, my, m_inf, kx, ky, k_inf,
    input  busy, out_valid, cx, cy, c_inf
  );

  modport slave (
    input  in_valid, mx, my, m_inf, kx, ky, k_inf,
    output busy, out_valid, cx, cy, c_inf
  );
endinterface

// File: rtl/ecc_mod_mul.sv
// Combinational modular multiplier: r = (a * b) mod P, using a 2W-bit product.
module ecc_mod_mul #(
  parameter int W = 8,
  parameter int P = 23
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] r
);

  localparam logic [2*W-1:0] P_2W = (2*W)'(P);

  logic [2*W-1:0] prod;

  // Full-width product, then reduce. P < 2^W, so the remainder fits in W bits.
  always_comb begin
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    r    = W'(prod % P_2W);
  end

endmodule

// File: rtl/ecc_cipher_add.sv
// Cipher-point adder: Pc = Pm + Km by affine point addition over GF(P).
// Degenerate cases are resolved in CHECK. The general case finds the
// denominator inverse by a sequential search, then forms lambda, xr and yr.
// All of these steps share a single modular multiplier.
module ecc_cipher_add
  import ecc_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int P = DEF_P,
  parameter int A = DEF_A
) (
  input  logic            clk,
  input  logic            reset,
  ecc_cipher_add_if.slave bus
);

  localparam logic [W-1:0] P_W  = W'(P);
  localparam logic [W:0]   P_W1 = (W+1)'(P);
  localparam logic [W+1:0] P_W2 = (W+2)'(P);
  localparam logic [W+1:0] A_W2 = (W+2)'(A % P);
  localparam logic [W-1:0] P_M1 = W'(P - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  // v mod P for a raw W-bit coordinate.
  function automatic logic [W-1:0] mod_red(input logic [W-1:0] v);
    return v % P_W;
  endfunction

  // (a - b) mod P, computed as (a + P - b) mod P so nothing goes negative.
  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + P_W1 - {1'b0, b};
    return W'(s % P_W1);
  endfunction

  add_state_t   state;
  logic [W-1:0] x1, y1, x2, y2;
  logic         m_inf_q, k_inf_q;
  logic [W-1:0] num, den, c, inv, lam, xr;
  logic         busy_q, out_valid_q, c_inf_q;
  logic [W-1:0] cx_q, cy_q;

  logic [W-1:0] mul_a, mul_b, mul_r;
  logic [W+1:0] dbl_num_t;
  logic [W:0]   dbl_den_t;
  logic [W-1:0] dbl_num, dbl_den;

  ecc_mod_mul #(.W(W), .P(P)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .r (mul_r)
  );

  // Select multiplier operands for the current step.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    mul_a = '0;
    mul_b = '0;
    unique case (state)
      ST_CHECK: begin mul_a = x1;  mul_b = x1;                 end  // x1^2
      ST_INV:   begin mul_a = den; mul_b = c;                  end  // den*c
      ST_SLOPE: begin mul_a = num; mul_b = inv;                end  // num/den
      ST_XR:    begin mul_a = lam; mul_b = lam;                end  // lambda^2
      ST_YR:    begin mul_a = lam; mul_b = mod_sub(x1, xr);    end  // lambda*(x1-xr)
      default:  begin mul_a = '0;  mul_b = '0;                 end
    endcase
  end

  // Doubling slope terms: num = 3*x1^2 + A, den = 2*y1. The multiplier supplies x1^2 in CHECK.
  always_comb begin
    dbl_num_t = {2'b00, mul_r} + {2'b00, mul_r} + {2'b00, mul_r} + A_W2;
    dbl_num   = W'(dbl_num_t % P_W2);
    dbl_den_t = {y1, 1'b0};
    dbl_den   = W'(dbl_den_t % P_W1);
  end

  // Sequencer: capture, classify, invert, then form lambda, xr and yr.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: every register, datapath included, is cleared on reset so an aborted operation leaves no stale operands behind.
    if (!reset) begin
      state       <= ST_IDLE;
      x1          <= '0;
      y1          <= '0;
      x2          <= '0;
      y2          <= '0;
      m_inf_q     <= 1'b0;
      k_inf_q     <= 1'b0;
      num         <= '0;
      den         <= '0;
      c           <= '0;
      inv         <= '0;
      lam         <= '0;
      xr          <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      cx_q        <= '0;
      cy_q        <= '0;
      c_inf_q     <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples the pre-edge values.
      out_valid_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            x1      <= mod_red(bus.mx);
            y1      <= mod_red(bus.my);
            m_inf_q <= bus.m_inf;
            x2      <= mod_red(bus.kx);
            y2      <= mod_red(bus.ky);
            k_inf_q <= bus.k_inf;
            busy_q  <= 1'b1;
            state   <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (m_inf_q || k_inf_q || (x1 == x2 && (y1 != y2 || y1 == '0))) begin
            // Direct result: identity operand, inverse pair, or vertical tangent.
            if (m_inf_q) begin
              cx_q    <= x2;
              cy_q    <= y2;
              c_inf_q <= k_inf_q;
            end else if (k_inf_q) begin
              cx_q    <= x1;
              cy_q    <= y1;
              c_inf_q <= PT_FINITE;
            end else begin
              cx_q    <= '0;
              cy_q    <= '0;
              c_inf_q <= PT_INF;
            end
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            if (x1 == x2) begin
              num <= dbl_num;
              den <= dbl_den;
            end else begin
              num <= mod_sub(y2, y1);
              den <= mod_sub(x2, x1);
            end
            c     <= ONE;
            state <= ST_INV;
          end
        end

        ST_INV: begin
          if (mul_r == ONE) begin
            inv   <= c;
            state <= ST_SLOPE;
          end else begin
            c <= c + ONE;
          end
        end

        ST_SLOPE: begin
          lam   <= mul_r;
          state <= ST_XR;
        end

        ST_XR: begin
          xr    <= mod_sub(mod_sub(mul_r, x1), x2);
          state <= ST_YR;
        end

        ST_YR: begin
          cx_q        <= xr;
          cy_q        <= mod_sub(mul_r, y1);
          c_inf_q     <= PT_FINITE;
          out_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state       <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // den is nonzero mod prime P, so its inverse is found by c = P-1 at the latest.
  assert property (@(posedge clk) disable iff (!reset)
                   (state == ST_INV && mul_r != ONE) |-> (c != P_M1));

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cx        = cx_q;
  assign bus.cy        = cy_q;
  assign bus.c_inf     = c_inf_q;

endmodule
